// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port and boot status of imem_loader.
// The host/bench side uses master; the loader uses slave.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        core_rst_n;
    logic        done;
    logic        error;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wd, core_rst_n, done, error
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wd, core_rst_n, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into 32-bit words,
// writes them to instruction memory and releases the core once the image verifies.
module imem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state, state_nx;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  lane;
    logic [7:0]  csum;
    logic [31:0] shreg;
    logic        accepting;
    logic        xfer;
    logic [15:0] len_full;

    assign accepting = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    // Ready is masked while rst is high so a reset cycle never consumes a byte.
    assign bus.byte_ready = accepting && !rst;
    assign xfer           = bus.byte_valid && bus.byte_ready;
    assign len_full       = {bus.byte_data, count[7:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= LEN0;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            LEN0:  if (xfer) state_nx = LEN1;
            LEN1: begin
                if (xfer) begin
                    if ({1'b0, len_full} > DEPTH_W) state_nx = ERR;
                    else if (len_full == 16'd0)     state_nx = CSUM;
                    else                            state_nx = DATA;
                end
            end
            DATA:  if (xfer && lane == 2'd3) state_nx = WRITE;
            WRITE: state_nx = ((word_idx + 16'd1) == count) ? CSUM : DATA;
            CSUM:  if (xfer) state_nx = (bus.byte_data == csum) ? DONE : ERR;
            DONE:  state_nx = DONE;
            ERR:   state_nx = ERR;
            default: state_nx = LEN0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            word_idx <= '0;
            lane     <= '0;
            csum     <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                LEN0: if (xfer) count[7:0]  <= bus.byte_data;
                LEN1: if (xfer) count[15:8] <= bus.byte_data;
                DATA: begin
                    if (xfer) begin
                        shreg[{lane, 3'b000} +: 8] <= bus.byte_data;
                        csum <= csum ^ bus.byte_data;
                        lane <= lane + 2'd1;
                    end
                end
                WRITE: word_idx <= word_idx + 16'd1;
                default: ;
            endcase
        end
    end

    // Address is decoded from the pre-increment word index during WRITE.
    assign bus.mem_we     = (state == WRITE);
    assign bus.mem_addr   = BASE_ADDR + {14'd0, word_idx, 2'b00};
    assign bus.mem_wd     = shreg;
    assign bus.done       = (state == DONE);
    assign bus.error      = (state == ERR);
    assign bus.core_rst_n = (state == DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts writes and final status,
// one negedge monitor checks every write strobe against it.
module tb_imem_loader;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int nwrites = 0;
    bit we_due = 1'b0;
    logic [31:0] img [0:DEPTH-1];
    logic [63:0] exp_q [$];
    logic [31:0] log_a [$];
    logic [31:0] log_d [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_xor(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++) x ^= img[i][8*b +: 8];
        return x;
    endfunction

    // Compare process: every strobe must match the next predicted write.
    always @(negedge clk) begin
        if (!rst) begin
            if (we_due) begin
                chk("we_latency", {31'd0, bus.mem_we}, 32'd1);
                we_due = 1'b0;
            end
            if (bus.mem_we) begin
                nwrites++;
                log_a.push_back(bus.mem_addr);
                log_d.push_back(bus.mem_wd);
                chk("ready_in_write", {31'd0, bus.byte_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("mem_addr", bus.mem_addr, e[63:32]);
                    chk("mem_wd", bus.mem_wd, e[31:0]);
                end
            end
            chk("core_rst_n_eq_done", {31'd0, bus.core_rst_n}, {31'd0, bus.done});
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
        chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_addr", bus.mem_addr, BASE);
        chk("rst_wd", bus.mem_wd, 32'd0);
        chk("rst_core", {31'd0, bus.core_rst_n}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_error", {31'd0, bus.error}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        log_a.delete();
        log_d.delete();
        nwrites = 0;
        we_due = 1'b0;
    endtask

    // Holds the byte until a ready cycle takes it; bounded wait.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit last_of_word);
        bit took = 1'b0;
        bit r;
        if (gaps) begin
            bus.byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        bus.byte_valid = 1'b1;
        bus.byte_data = b;
        for (int k = 0; k < 50 && !took; k++) begin
            @(negedge clk);
            r = bus.byte_ready;
            @(posedge clk);
            #1;
            if (r) took = 1'b1;
        end
        bus.byte_valid = 1'b0;
        if (!took) chk("send_timeout", 32'd0, 32'd1);
        else if (last_of_word) we_due = 1'b1;
    endtask

    task automatic run_load(input int n, input logic [7:0] cs, input bit gaps);
        logic [15:0] nn;
        bit ok;
        nn = 16'(n);
        ok = (cs == model_xor(n));
        for (int i = 0; i < n; i++) exp_q.push_back({BASE + 32'(4 * i), img[i]});
        send_byte(nn[7:0], gaps, 1'b0);
        send_byte(nn[15:8], gaps, 1'b0);
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8], gaps, b == 3);
        send_byte(cs, gaps, 1'b0);
        @(negedge clk);
        chk("end_done", {31'd0, bus.done}, {31'd0, ok});
        chk("end_error", {31'd0, bus.error}, {31'd0, !ok});
        chk("end_core", {31'd0, bus.core_rst_n}, {31'd0, ok});
        chk("end_ready", {31'd0, bus.byte_ready}, 32'd0);
        chk("end_nwrites", 32'(nwrites), 32'(n));
        chk("end_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_overflow(input logic [15:0] nn);
        send_byte(nn[7:0], 1'b0, 1'b0);
        send_byte(nn[15:8], 1'b0, 1'b0);
        @(negedge clk);
        chk("ovf_error", {31'd0, bus.error}, 32'd1);
        chk("ovf_done", {31'd0, bus.done}, 32'd0);
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'h93;
        repeat (4) begin
            @(negedge clk);
            chk("ovf_ready", {31'd0, bus.byte_ready}, 32'd0);
        end
        bus.byte_valid = 1'b0;
        chk("ovf_nwrites", 32'(nwrites), 32'd0);
        chk("ovf_core", {31'd0, bus.core_rst_n}, 32'd0);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;

        // Two-word image, correct checksum, back-to-back delivery.
        do_reset();
        img[0] = 32'h0050_0093;
        img[1] = 32'h00A0_0113;
        chk("model_csum_2w", {24'd0, model_xor(2)}, 32'h71);
        run_load(2, 8'h71, 1'b0);
        if (log_a.size() == 2) begin
            chk("lit_addr0", log_a[0], 32'h0000_0100);
            chk("lit_data0", log_d[0], 32'h0050_0093);
            chk("lit_addr1", log_a[1], 32'h0000_0104);
            chk("lit_data1", log_d[1], 32'h00A0_0113);
        end else chk("lit_count", 32'(log_a.size()), 32'd2);

        // Bad checksums: writes still happen, then error.
        do_reset();
        run_load(2, 8'h41, 1'b0);
        do_reset();
        run_load(2, 8'h40, 1'b0);

        // Length overflow, just past DEPTH and with a nonzero high byte.
        do_reset();
        run_overflow(16'h0041);
        do_reset();
        run_overflow(16'h0100);

        // Empty image.
        do_reset();
        run_load(0, 8'h00, 1'b0);
        do_reset();
        run_load(0, 8'h01, 1'b0);

        // Host gaps must not change the write sequence.
        do_reset();
        run_load(2, 8'h71, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) img[i] = $urandom;
        run_load(5, model_xor(5), 1'b1);

        // Reset mid-word, then a fresh single-word stream.
        do_reset();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'hEF, 1'b0, 1'b0);
        send_byte(8'hBE, 1'b0, 1'b0);
        do_reset();
        img[0] = 32'hDEAD_BEEF;
        chk("model_csum_dead", {24'd0, model_xor(1)}, 32'h22);
        run_load(1, 8'h22, 1'b0);
        if (log_a.size() == 1) begin
            chk("lit_dead_addr", log_a[0], 32'h0000_0100);
            chk("lit_dead_data", log_d[0], 32'hDEAD_BEEF);
        end else chk("lit_dead_count", 32'(log_a.size()), 32'd1);

        // Largest legal image.
        do_reset();
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        run_load(DEPTH, model_xor(DEPTH), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
